// File: rtl/ysyx_csr_trap_seq_if.sv
// Bundle between the commit stage, the machine-mode CSR file and the IFU redirect
// port, as seen by the CSR/trap sequencer.
//   commit side : cmt_valid/cmt_ready handshake plus pc, CSR write fields and kind flags
//   CSR file    : mtvec_i/mepc_i read values in; dual-write port (exu_valid, wen,
//                 ecallen, waddr/wdata, waddr_add1/wdata_add1) out
//   IFU         : redirect_valid/redirect_ready handshake with redirect_pc
//   status      : busy
// master drives the commit/CSR-read/IFU-ready side; slave is the sequencer.
interface ysyx_csr_trap_seq_if #(
   parameter int XLEN   = 32,
   parameter int CSR_AW = 12
);
   logic              cmt_valid;
   logic              cmt_ready;
   logic [XLEN-1:0]   cmt_pc;
   logic              cmt_csr_wen;
   logic [CSR_AW-1:0] cmt_csr_addr;
   logic [XLEN-1:0]   cmt_csr_wdata;
   logic              cmt_ecall;
   logic              cmt_mret;
   logic [XLEN-1:0]   mtvec_i;
   logic [XLEN-1:0]   mepc_i;
   logic              csr_exu_valid;
   logic              csr_wen;
   logic              csr_ecallen;
   logic [CSR_AW-1:0] csr_waddr;
   logic [CSR_AW-1:0] csr_waddr_add1;
   logic [XLEN-1:0]   csr_wdata;
   logic [XLEN-1:0]   csr_wdata_add1;
   logic              redirect_valid;
   logic              redirect_ready;
   logic [XLEN-1:0]   redirect_pc;
   logic              busy;

   modport master (
      output cmt_valid, cmt_pc, cmt_csr_wen, cmt_csr_addr, cmt_csr_wdata,
             cmt_ecall, cmt_mret, mtvec_i, mepc_i, redirect_ready,
      input  cmt_ready, csr_exu_valid, csr_wen, csr_ecallen, csr_waddr,
             csr_waddr_add1, csr_wdata, csr_wdata_add1, redirect_valid,
             redirect_pc, busy
   );

   modport slave (
      input  cmt_valid, cmt_pc, cmt_csr_wen, cmt_csr_addr, cmt_csr_wdata,
             cmt_ecall, cmt_mret, mtvec_i, mepc_i, redirect_ready,
      output cmt_ready, csr_exu_valid, csr_wen, csr_ecallen, csr_waddr,
             csr_waddr_add1, csr_wdata, csr_wdata_add1, redirect_valid,
             redirect_pc, busy
   );
endinterface

// File: rtl/ysyx_csr_trap_seq.sv
// Commit-side sequencer for the machine-mode CSR file and trap/return flow.
// Takes one retiring instruction per cmt handshake and turns it into CSR-file
// write cycles and, for ecall/mret, an IFU redirect held until accepted.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : ysyx_csr_trap_seq_if.slave (commit handshake, CSR-file port, IFU redirect, busy)
//
// state | meaning
// IDLE  | ready for a retiring instruction
// TRAP  | one cycle: write mepc/mcause, MPIE<=MIE, MIE<=0
// CSRW  | one cycle: plain CSR write of the latched addr/data
// REDIR | redirect to latched target, waiting for IFU accept
module ysyx_csr_trap_seq #(
   parameter int                XLEN         = 32,
   parameter int                CSR_AW       = 12,
   parameter logic [XLEN-1:0]   MCAUSE_ECALL = 32'd11,
   parameter logic [CSR_AW-1:0] ADDR_MEPC    = 12'h341,
   parameter logic [CSR_AW-1:0] ADDR_MCAUSE  = 12'h342
) (
   input logic               clk,
   input logic               rst,
   ysyx_csr_trap_seq_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRAP  = 2'd1,
      CSRW  = 2'd2,
      REDIR = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   wdata_q;
   logic [XLEN-1:0]   tgt_q;
   logic [CSR_AW-1:0] addr_q;
   logic              accept;

   assign bus.cmt_ready = (state_q == IDLE) & ~rst;
   assign accept        = bus.cmt_valid & bus.cmt_ready;
   assign bus.busy      = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            pc_q    <= bus.cmt_pc;
            addr_q  <= bus.cmt_csr_addr;
            wdata_q <= bus.cmt_csr_wdata;
         end
         // mret returns to mepc as it stood at accept; a trap jumps to mtvec
         // as seen during its write cycle.
         if (accept && !bus.cmt_ecall && bus.cmt_mret)
            tgt_q <= bus.mepc_i;
         else if (state_q == TRAP)
            tgt_q <= bus.mtvec_i;
      end
   end

   always_comb begin
      state_d            = state_q;
      bus.csr_exu_valid  = 1'b0;
      bus.csr_wen        = 1'b0;
      bus.csr_ecallen    = 1'b0;
      bus.csr_waddr      = '0;
      bus.csr_waddr_add1 = '0;
      bus.csr_wdata      = '0;
      bus.csr_wdata_add1 = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (bus.cmt_ecall)        state_d = TRAP;
               else if (bus.cmt_mret)    state_d = REDIR;
               else if (bus.cmt_csr_wen) state_d = CSRW;
            end
         end
         TRAP: begin
            bus.csr_exu_valid  = 1'b1;
            bus.csr_wen        = 1'b1;
            bus.csr_ecallen    = 1'b1;
            bus.csr_waddr      = ADDR_MEPC;
            bus.csr_wdata      = pc_q;
            bus.csr_waddr_add1 = ADDR_MCAUSE;
            bus.csr_wdata_add1 = MCAUSE_ECALL;
            state_d            = REDIR;
         end
         CSRW: begin
            // secondary port parked on the unmapped address 0
            bus.csr_exu_valid = 1'b1;
            bus.csr_wen       = 1'b1;
            bus.csr_waddr     = addr_q;
            bus.csr_wdata     = wdata_q;
            state_d           = IDLE;
         end
         REDIR: begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = tgt_q;
            if (bus.redirect_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ysyx_csr_trap_seq.sv
// Bench for ysyx_csr_trap_seq: directed latency checks plus randomized traffic.
// Expected CSR writes and redirects are queued when a request is issued and a
// monitor compares them against what the sequencer presents.
module tb_ysyx_csr_trap_seq;
   localparam int XLEN   = 32;
   localparam int CSR_AW = 12;

   typedef struct {
      logic        ecallen;
      logic [11:0] a;
      logic [31:0] d;
      logic [11:0] a1;
      logic [31:0] d1;
   } csr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   csr_t        csr_q[$];
   logic [31:0] redir_q[$];

   logic rr_rand  = 1'b0;
   logic rr_force = 1'b0;
   logic rr_rnd   = 1'b0;

   logic        pv  = 1'b0;
   logic        pr  = 1'b0;
   logic [31:0] ppc = '0;

   ysyx_csr_trap_seq_if #(.XLEN(XLEN), .CSR_AW(CSR_AW)) bus();

   ysyx_csr_trap_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.redirect_ready = rr_rand ? rr_rnd : rr_force;

   initial forever begin
      @(posedge clk);
      #1;
      rr_rnd = ($urandom % 3) != 0;
   end

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference: what a retiring instruction must cause, from the kind priority.
   task automatic model(input logic e, input logic m, input logic w,
                        input logic [31:0] pc, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] mtvec, input logic [31:0] mepc);
      csr_t c;
      if (e) begin
         c = '{1'b1, 12'h341, pc, 12'h342, 32'd11};
         csr_q.push_back(c);
         redir_q.push_back(mtvec);
      end else if (m) begin
         redir_q.push_back(mepc);
      end else if (w) begin
         c = '{1'b0, a, d, 12'h000, 32'h0};
         csr_q.push_back(c);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic m, input logic w,
                        input logic [31:0] pc, input logic [11:0] a, input logic [31:0] d);
      bus.cmt_ecall     = e;
      bus.cmt_mret      = m;
      bus.cmt_csr_wen   = w;
      bus.cmt_pc        = pc;
      bus.cmt_csr_addr  = a;
      bus.cmt_csr_wdata = d;
      bus.cmt_valid     = 1'b1;
   endtask

   task automatic junk();
      bus.cmt_valid     = 1'b0;
      bus.cmt_ecall     = 1'($urandom);
      bus.cmt_mret      = 1'($urandom);
      bus.cmt_csr_wen   = 1'($urandom);
      bus.cmt_pc        = $urandom;
      bus.cmt_csr_addr  = 12'($urandom);
      bus.cmt_csr_wdata = $urandom;
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (!bus.cmt_ready && n < 100) begin
         step();
         n++;
      end
      chk(nm, 64'(bus.cmt_ready), 64'd1);
   endtask

   task automatic issue(input logic e, input logic m, input logic w,
                        input logic [31:0] pc, input logic [11:0] a, input logic [31:0] d);
      wait_ready("ready_timeout");
      bus.mtvec_i = $urandom & 32'hffff_fffc;
      bus.mepc_i  = $urandom & 32'hffff_fffc;
      drive(e, m, w, pc, a, d);
      model(e, m, w, pc, a, d, bus.mtvec_i, bus.mepc_i);
      step();
      junk();
      step();
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ctl"}, {58'd0, bus.cmt_ready, bus.csr_exu_valid, bus.csr_wen,
                         bus.csr_ecallen, bus.redirect_valid, bus.busy}, 64'd0);
      chk({nm, "_addr"}, {40'd0, bus.csr_waddr, bus.csr_waddr_add1}, 64'd0);
      chk({nm, "_data"}, {bus.csr_wdata, bus.csr_wdata_add1}, 64'd0);
      chk({nm, "_rpc"}, 64'(bus.redirect_pc), 64'd0);
   endtask

   // Monitor: pops expectations whenever the DUT shows a CSR write or a redirect handshake.
   initial forever begin
      csr_t c;
      @(negedge clk);
      if (rst) begin
         pv = 1'b0;
      end else begin
         if (bus.csr_exu_valid) begin
            if (csr_q.size() == 0) begin
               chk("csr_unexpected", 64'(bus.csr_exu_valid), 64'd0);
            end else begin
               c = csr_q.pop_front();
               chk("csr_wen", 64'(bus.csr_wen), 64'd1);
               chk("csr_ecallen", 64'(bus.csr_ecallen), 64'(c.ecallen));
               chk("csr_waddr", 64'(bus.csr_waddr), 64'(c.a));
               chk("csr_wdata", 64'(bus.csr_wdata), 64'(c.d));
               chk("csr_waddr_add1", 64'(bus.csr_waddr_add1), 64'(c.a1));
               chk("csr_wdata_add1", 64'(bus.csr_wdata_add1), 64'(c.d1));
            end
         end else begin
            chk("csr_idle", {bus.csr_wen, bus.csr_ecallen, 19'd0, bus.csr_waddr_add1,
                             bus.csr_wdata_add1}, 64'd0);
         end
         if (pv && !pr) begin
            chk("redir_hold", 64'(bus.redirect_valid), 64'd1);
            chk("redir_pc_stable", 64'(bus.redirect_pc), 64'(ppc));
         end
         if (bus.redirect_valid && bus.redirect_ready) begin
            if (redir_q.size() == 0)
               chk("redir_unexpected", 64'(bus.redirect_valid), 64'd0);
            else
               chk("redir_pc", 64'(bus.redirect_pc), 64'(redir_q.pop_front()));
         end
         pv  = bus.redirect_valid;
         pr  = bus.redirect_ready;
         ppc = bus.redirect_pc;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic e, m, w;
      bus.cmt_valid = 1'b0;
      junk();
      bus.mtvec_i = '0;
      bus.mepc_i  = '0;

      // T1: reset
      step();
      step();
      chk_all_zero("t1_rst");
      rst = 1'b0;
      #1;
      chk("t1_ready", 64'(bus.cmt_ready), 64'd1);
      chk("t1_busy", 64'(bus.busy), 64'd0);

      // T2: ecall with immediate redirect accept
      rr_rand     = 1'b0;
      rr_force    = 1'b1;
      bus.mtvec_i = 32'h8000_0400;
      bus.mepc_i  = 32'h1234_5678;
      drive(1'b1, 1'b0, 1'b0, 32'h8000_0100, 12'h0ab, 32'hdead_beef);
      model(1'b1, 1'b0, 1'b0, 32'h8000_0100, 12'h0ab, 32'hdead_beef, bus.mtvec_i, bus.mepc_i);
      step();
      junk();
      chk("t2_csr_ctl", {61'd0, bus.csr_exu_valid, bus.csr_wen, bus.csr_ecallen}, 64'd7);
      chk("t2_waddr", 64'(bus.csr_waddr), 64'h341);
      chk("t2_wdata", 64'(bus.csr_wdata), 64'h8000_0100);
      chk("t2_waddr_add1", 64'(bus.csr_waddr_add1), 64'h342);
      chk("t2_wdata_add1", 64'(bus.csr_wdata_add1), 64'd11);
      chk("t2_no_ready", 64'(bus.cmt_ready), 64'd0);
      chk("t2_no_redir_yet", 64'(bus.redirect_valid), 64'd0);
      step();
      chk("t2_redir_valid", 64'(bus.redirect_valid), 64'd1);
      chk("t2_redir_pc", 64'(bus.redirect_pc), 64'h8000_0400);
      chk("t2_no_csr", 64'(bus.csr_exu_valid), 64'd0);
      step();
      chk("t2_ready_back", 64'(bus.cmt_ready), 64'd1);
      chk("t2_busy", 64'(bus.busy), 64'd0);

      // T3: plain CSR write, one bubble
      drive(1'b0, 1'b0, 1'b1, 32'h8000_0200, 12'h305, 32'h8000_0000);
      model(1'b0, 1'b0, 1'b1, 32'h8000_0200, 12'h305, 32'h8000_0000, bus.mtvec_i, bus.mepc_i);
      step();
      junk();
      chk("t3_wen", {62'd0, bus.csr_exu_valid, bus.csr_wen}, 64'd3);
      chk("t3_ecallen", 64'(bus.csr_ecallen), 64'd0);
      chk("t3_waddr", 64'(bus.csr_waddr), 64'h305);
      chk("t3_wdata", 64'(bus.csr_wdata), 64'h8000_0000);
      chk("t3_add1", 64'(bus.csr_waddr_add1), 64'd0);
      chk("t3_bubble", 64'(bus.cmt_ready), 64'd0);
      step();
      chk("t3_ready", 64'(bus.cmt_ready), 64'd1);
      chk("t3_no_redir", 64'(bus.redirect_valid), 64'd0);

      // T4: mret with IFU stalling 3 cycles
      rr_force   = 1'b0;
      bus.mepc_i = 32'h8000_0104;
      drive(1'b0, 1'b1, 1'b0, 32'h8000_0300, 12'h300, 32'h1);
      model(1'b0, 1'b1, 1'b0, 32'h8000_0300, 12'h300, 32'h1, bus.mtvec_i, bus.mepc_i);
      step();
      junk();
      bus.mepc_i = 32'h0bad_0bad;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) rr_force = 1'b1;
         chk("t4_redir_valid", 64'(bus.redirect_valid), 64'd1);
         chk("t4_redir_pc", 64'(bus.redirect_pc), 64'h8000_0104);
         chk("t4_not_ready", 64'(bus.cmt_ready), 64'd0);
         chk("t4_no_csr", 64'(bus.csr_exu_valid), 64'd0);
         step();
      end
      chk("t4_ready", 64'(bus.cmt_ready), 64'd1);

      // T5: all kind flags set -> trap only
      rr_rand = 1'b1;
      issue(1'b1, 1'b1, 1'b1, 32'h8000_0500, 12'h305, 32'h5555_aaaa);
      wait_ready("t5_done");

      // T6: reset in the TRAP cycle abandons the sequence
      rr_rand  = 1'b0;
      rr_force = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 32'h8000_0600, 12'h000, 32'h0);
      step();
      junk();
      rst = 1'b1;
      step();
      chk_all_zero("t6_rst");
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("t6_idle", 64'(bus.cmt_ready), 64'd1);

      // Random traffic
      rr_rand = 1'b1;
      for (int i = 0; i < 80; i++) begin
         e = ($urandom % 4) == 0;
         m = ($urandom % 3) == 0;
         w = ($urandom % 2) == 0;
         issue(e, m, w, $urandom & 32'hffff_fffc, 12'($urandom), $urandom);
      end
      wait_ready("final_idle");
      step();
      step();
      chk("csr_q_drained", 64'(csr_q.size()), 64'd0);
      chk("redir_q_drained", 64'(redir_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
